// File: rtl/c157x_track_loader.sv
// c157x_track_loader
// Track-level SD transfer sequencer for the 1541/157x drive model. Moves whole
// track images between the drive track buffer and the SD host. It writes the
// loaded track back when save_track toggles, and reads a new track once the
// requested slot has been stable for SETTLE cycles.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   track        : requested track slot (side offset already applied)
//   save_track   : toggle; every edge requests write-back of the loaded track
//   change       : image-mounted level; a rising edge means a new image
//   sd_ack       : SD host acknowledge, high for the duration of a transfer
//   sd_lba       : LBA of the current request (track * BLK_CNT)
//   sd_rd, sd_wr : read / write requests (never both high)
//   busy         : high whenever the sequencer is not idle
//   cur_track    : slot currently held in the buffer, 8'hFF = none
//   err          : watchdog expiry flag (only with C157X_TRACK_TIMEOUT_EN)
//
// Optional feature macro: C157X_TRACK_TIMEOUT_EN adds the err output and a
// 20-bit transfer watchdog. Without it the FSM waits for the host indefinitely.
//
// SD handshake: a request (sd_rd or sd_wr) together with sd_lba is held until
// sd_ack rises. The request drops on the next edge, and the transfer is complete
// when sd_ack falls. sd_lba stays unchanged from request assertion until then.
module c157x_track_loader #(
  parameter int BLK_CNT   = 52,
  parameter int MAX_TRACK = 168,
  parameter int SETTLE    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  track,
  input  logic        save_track,
  input  logic        change,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        busy,
  output logic [7:0]  cur_track
`ifdef C157X_TRACK_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [8:0] MAX_T = 9'(MAX_TRACK);
  localparam logic [7:0] NONE = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    settle_trk;  // value being timed for stability
  logic [7:0]    tgt;         // slot being read
  logic          save_old, chg_old, ack_old;
  logic          save_pending;
  logic          discard;     // image changed mid-transfer: do not commit

  logic ack_rise, ack_fall, save_edge, chg_edge, in_range, xfer, done, want_wr;

  function automatic logic [31:0] lba_of(input logic [7:0] t);
    return 32'(t) * 32'(BLK_CNT);
  endfunction

  assign ack_rise  = sd_ack & ~ack_old;
  assign ack_fall  = ~sd_ack & ack_old;
  assign save_edge = save_track ^ save_old;
  assign chg_edge  = change & ~chg_old;
  assign in_range  = {1'b0, track} < MAX_T;
  assign xfer      = (state == S_WR_REQ) || (state == S_WR_WAIT) ||
                     (state == S_RD_REQ) || (state == S_RD_WAIT);
  // A change edge on this cycle wipes cur_track, so a write must not start.
  assign want_wr   = save_pending && !chg_edge && (cur_track != NONE);
  assign busy      = (state != S_IDLE);

`ifdef C157X_TRACK_TIMEOUT_EN
  logic [19:0] wdog;
  logic        tmo;
  assign tmo  = xfer && (wdog == 20'hFFFFF);
  assign done = (((state == S_WR_WAIT) || (state == S_RD_WAIT)) && ack_fall) || tmo;
`else
  assign done = ((state == S_WR_WAIT) || (state == S_RD_WAIT)) && ack_fall;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      settle_trk   <= '0;
      tgt          <= '0;
      save_pending <= 1'b0;
      discard      <= 1'b0;
      cur_track    <= NONE;
      sd_lba       <= '0;
      sd_rd        <= 1'b0;
      sd_wr        <= 1'b0;
      save_old     <= save_track;
      chg_old      <= change;
      ack_old      <= sd_ack;
`ifdef C157X_TRACK_TIMEOUT_EN
      wdog         <= '0;
      err          <= 1'b0;
`endif
    end else begin
      save_old <= save_track;
      chg_old  <= change;
      ack_old  <= sd_ack;

      case (state)
        S_IDLE: begin
          if (want_wr) begin
            state <= S_WR_REQ;
          end else begin
            // Nothing loaded means nothing to write back.
            if (save_pending && cur_track == NONE) save_pending <= 1'b0;
            if (track != cur_track && in_range) begin
              state      <= S_SETTLE;
              cnt        <= CW'(SETTLE - 1);
              settle_trk <= track;
            end
          end
        end
        S_SETTLE: begin
          if (want_wr) begin
            state <= S_WR_REQ;            // settling restarts from IDLE later
          end else if (!in_range) begin
            state <= S_IDLE;
          end else if (track != settle_trk) begin
            cnt        <= CW'(SETTLE - 1);
            settle_trk <= track;
          end else if (cnt == '0) begin
            state <= S_RD_REQ;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WR_REQ: begin
          if (!sd_wr) begin
            sd_lba <= lba_of(cur_track);
            sd_wr  <= 1'b1;
          end else if (ack_rise) begin
            sd_wr        <= 1'b0;
            save_pending <= 1'b0;
            state        <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (ack_fall) begin
            state   <= S_IDLE;
            discard <= 1'b0;
            if (discard || chg_edge) cur_track <= NONE;
          end
        end
        S_RD_REQ: begin
          if (!sd_rd) begin
            tgt    <= settle_trk;
            sd_lba <= lba_of(settle_trk);
            sd_rd  <= 1'b1;
          end else if (ack_rise) begin
            sd_rd <= 1'b0;
            state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (ack_fall) begin
            state     <= S_IDLE;
            discard   <= 1'b0;
            cur_track <= (discard || chg_edge) ? NONE : tgt;
          end
        end
        default: state <= S_IDLE;
      endcase

`ifdef C157X_TRACK_TIMEOUT_EN
      if (!xfer) wdog <= '0;              // entry to a *_REQ state starts at 0
      else if (!tmo) wdog <= wdog + 1'b1;
      if (tmo) begin
        sd_rd        <= 1'b0;
        sd_wr        <= 1'b0;
        err          <= 1'b1;
        cur_track    <= NONE;
        save_pending <= 1'b0;
        discard      <= 1'b0;
        state        <= S_IDLE;
      end
`endif

      // Set after the FSM clear so an edge coinciding with the write ack is kept.
      if (save_edge) save_pending <= 1'b1;

      if (chg_edge) begin
        save_pending <= 1'b0;
        if (!xfer) cur_track <= NONE;
        else if (!done) discard <= 1'b1;
`ifdef C157X_TRACK_TIMEOUT_EN
        err <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_c157x_track_loader.sv
// Self-checking bench for c157x_track_loader. The expected SD request stream
// ({is_write, lba}) comes from a slot-level model of the loader and is queued
// when stimulus is issued. A monitor pops one entry per request it observes.
module tb_c157x_track_loader;

  localparam int BLK = 52;
  localparam int MAXT = 168;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  track;
  logic        save_track;
  logic        change;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, busy;
  logic [7:0]  cur_track;
`ifdef C157X_TRACK_TIMEOUT_EN
  logic        err;
`endif

  c157x_track_loader dut (
    .clk(clk), .reset(reset), .track(track), .save_track(save_track),
    .change(change), .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd),
    .sd_wr(sd_wr), .busy(busy), .cur_track(cur_track)
`ifdef C157X_TRACK_TIMEOUT_EN
    , .err(err)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];   // {is_write, lba}
  int checks = 0;
  int errors = 0;
  int req_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_rd(input int t);
    exp_q.push_back({1'b0, 32'(t * BLK)});
  endtask

  task automatic push_wr(input int t);
    exp_q.push_back({1'b1, 32'(t * BLK)});
  endtask

  // ---------------- monitor ----------------
  logic        prev_rd = 1'b0, prev_wr = 1'b0, active = 1'b0, ack_seen = 1'b0;
  logic [31:0] held_lba = '0;
  logic [32:0] e;

  always @(negedge clk) begin
    if (!reset) begin
      if ((sd_rd && !prev_rd) || (sd_wr && !prev_wr)) begin
        req_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got wr=%0d lba=%0d expected none", sd_wr, sd_lba);
        end else begin
          e = exp_q.pop_front();
          check("req_kind_wr", 32'(sd_wr), 32'(e[32]));
          check("req_lba", sd_lba, e[31:0]);
        end
        held_lba = sd_lba;
        active   = 1'b1;
        ack_seen = 1'b0;
      end
      if (sd_rd || sd_wr) check("rd_wr_exclusive", 32'(sd_rd && sd_wr), 32'd0);
      if (active) begin
        check("lba_stable", sd_lba, held_lba);
        if (sd_ack) ack_seen = 1'b1;
        else if (ack_seen) active = 1'b0;
      end
    end else begin
      active = 1'b0;
    end
    prev_rd = sd_rd;
    prev_wr = sd_wr;
  end

  // ---------------- SD host responder ----------------
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && (sd_rd || sd_wr) && !sd_ack) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 sd_ack = 1'b1;
        for (int n = 0; n < 100 && (sd_rd || sd_wr); n++) begin
          @(posedge clk);
          #1;
        end
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 sd_ack = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_change();
    change = 1'b1;
    cyc(3);
    change = 1'b0;
  endtask

  // Waits until the loader and host have been idle long enough that any
  // settle window would have shown up as busy.
  task automatic wait_quiet();
    int q, n;
    q = 0;
    n = 0;
    while (q < 25 && n < 5000) begin
      @(negedge clk);
      n++;
      if (busy || sd_ack) q = 0;
      else q++;
    end
    check("quiet_reached", 32'(q >= 25), 32'd1);
    cyc(1);
  endtask

  // ---------------- stimulus ----------------
  int n, start, busy_cnt, op, t;
  int cur_m, trk_m;

  initial begin
    reset = 1'b1;
    track = 8'd36;
    save_track = 1'b0;
    change = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sd_rd", 32'(sd_rd), 32'd0);
    check("reset_sd_wr", 32'(sd_wr), 32'd0);
    check("reset_sd_lba", sd_lba, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cur_track", 32'(cur_track), 32'hFF);

    // Test 1: first load of track 36, read starts 17 cycles after busy rises.
    push_rd(36);
    @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sd_rd && n < 100);
    check("settle_latency", 32'(n), 32'd17);
    wait_quiet();
    check("t1_cur_track", 32'(cur_track), 32'd36);
    check("t1_busy", 32'(busy), 32'd0);

    // Test 2: save toggle and new track together: write first, then read.
    push_wr(36);
    push_rd(38);
    save_track = ~save_track;
    track = 8'd38;
    wait_quiet();
    check("t2_cur_track", 32'(cur_track), 32'd38);

    // Test 3: track flapping faster than the settle window issues no read.
    start = req_count;
    track = 8'd36;
    for (int i = 0; i < 4; i++) begin
      cyc(8);
      track = track ^ 8'd1;
    end
    check("t3_no_read_while_flapping", 32'(req_count), 32'(start));
    check("t3_busy_settling", 32'(busy), 32'd1);
    push_rd(36);
    wait_quiet();
    check("t3_cur_track", 32'(cur_track), 32'd36);

    // Test 4: image change during the read of track 40: not committed, re-read.
    push_rd(40);
    push_rd(40);
    track = 8'd40;
    n = 0;
    while (!sd_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_ack_seen", 32'(sd_ack), 32'd1);
    cyc(1);
    pulse_change();
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_cur_after_discard", 32'(cur_track), 32'hFF);
    wait_quiet();
    check("t4_cur_track", 32'(cur_track), 32'd40);

    // Test 5: out-of-range slot never starts a load.
    start = req_count;
    busy_cnt = 0;
    track = 8'd170;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("t5_busy_never", 32'(busy_cnt), 32'd0);
    check("t5_no_request", 32'(req_count), 32'(start));
    check("t5_cur_track", 32'(cur_track), 32'd40);
    cyc(1);

    // Randomized phase against the slot-level model.
    cur_m = 40;
    trk_m = 170;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 4);
      if ((op == 1 || op == 2) && cur_m == 255) op = 0;
      case (op)
        0: begin
          t = $urandom_range(0, MAXT - 1);
          if (t != cur_m) begin
            push_rd(t);
            cur_m = t;
          end
          trk_m = t;
          track = 8'(t);
        end
        1: begin
          push_wr(cur_m);
          save_track = ~save_track;
        end
        2: begin
          t = $urandom_range(0, MAXT - 1);
          push_wr(cur_m);
          if (t != cur_m) push_rd(t);
          cur_m = t;
          trk_m = t;
          save_track = ~save_track;
          track = 8'(t);
        end
        3: begin
          t = $urandom_range(MAXT, 255);
          trk_m = t;
          track = 8'(t);
        end
        default: begin
          cur_m = 255;
          if (trk_m < MAXT) begin
            push_rd(trk_m);
            cur_m = trk_m;
          end
          pulse_change();
        end
      endcase
      wait_quiet();
      check("rand_cur_track", 32'(cur_track), 32'(cur_m));
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/c157x_track_loader.md
Name: c157x_track_loader

Overview:
- Track-level SD transfer sequencer for the 1541/157x drive model.
- Consumes the drive's requested track number and the save-request toggle.
- Issues whole-track sd_rd/sd_wr requests toward the SD host, computing the LBA for each.
- Sits between the drive top-level track/step logic and the SD block interface. Reports busy so the head/GCR stages stall while the track buffer is being refilled or flushed.

Parameters:
BLK_CNT, 52, 256-byte SD blocks per track image slot; LBA = track * BLK_CNT.
MAX_TRACK, 168, number of valid track slots (84 per side x 2); track >= MAX_TRACK is out of range.
SETTLE, 16, cycles a new track number must stay stable before a read is started (SETTLE >= 1).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
track  in  8  requested track slot (side offset already applied)
save_track  in  1  toggle; every edge requests a write-back of the loaded track
change  in  1  image-mounted level; rising edge = new image
sd_ack  in  1  SD host acknowledge, high for the duration of a transfer
sd_lba  out  32  LBA of current request
sd_rd  out  1  read request
sd_wr  out  1  write request
busy  out  1  high whenever state != IDLE
cur_track  out  8  slot currently held in the buffer; 8'hFF = none

Behaviour:
- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, busy=0, cur_track=8'hFF, save_pending=0, state=IDLE, settle counter=0. Internal toggle/edge history registers load their current inputs.
- Edge detect: save_old <= save_track; a mismatch sets save_pending. chg_old <= change; a rising edge sets cur_track=8'hFF and clears save_pending (old image is discarded, never written).
- States: IDLE, SETTLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.
- IDLE:
  - save_pending and cur_track!=FF -> WR_REQ; write has priority.
  - Otherwise, track!=cur_track and track<MAX_TRACK -> SETTLE with counter=SETTLE-1.
  - track>=MAX_TRACK never starts a load; cur_track is kept.
- SETTLE:
  - Counts down while track is unchanged. Any change of track reloads the counter.
  - Counter reaches 0 -> RD_REQ.
  - save_pending becoming set during SETTLE -> WR_REQ; SETTLE restarts afterwards.
- WR_REQ:
  - sd_lba = cur_track*BLK_CNT (32-bit, zero-extended), sd_wr=1. Hold both until sd_ack rises.
  - On the sd_ack rising edge: sd_wr=0, clear save_pending, -> WR_WAIT.
  - A save edge arriving during WR_WAIT sets save_pending again and is serviced later.
- WR_WAIT: sd_ack falls -> IDLE.
- RD_REQ:
  - Latch the target track into an internal tgt register. sd_lba = tgt*BLK_CNT, sd_rd=1.
  - On the sd_ack rising edge: sd_rd=0 -> RD_WAIT.
- RD_WAIT: sd_ack falls -> cur_track <= tgt -> IDLE. A track change during the read does not abort it; IDLE re-evaluates afterwards.
- sd_rd and sd_wr are never high together. Each is asserted for at least 1 cycle and dropped within 1 cycle of the sd_ack rise.
- sd_lba is stable from request assertion until sd_ack falls.
- A change edge during WR_*/RD_* lets the SD handshake complete, then forces cur_track=FF. The write result is discarded, and the read result is not committed.
- Reset mid-transfer: all outputs return to reset values on the next clk edge. The host must tolerate request withdrawal.

Optional Feature:
- Macro: C157X_TRACK_TIMEOUT_EN.
- When defined:
  - Adds output err (1 bit, reset 0) and a 20-bit watchdog, cleared on entry to any *_REQ state.
  - If the watchdog reaches 2^20-1 in *_REQ or *_WAIT without the expected sd_ack edge: drop sd_rd/sd_wr, set err=1, set cur_track=FF, clear save_pending, -> IDLE.
  - err clears on reset or a change rising edge.
- When undefined: no err port, no watchdog; the FSM waits indefinitely.

Test Plan:
1. After reset, track=36 stable, SETTLE=16 -> sd_rd rises 17 cycles after IDLE sees the mismatch with sd_lba=1872; ack pulse -> cur_track=36, busy=0.
2. cur_track=36, toggle save_track, set track=38 -> sd_wr with lba=1872 first, then after the ack cycle sd_rd with lba=1976; cur_track=38.
3. Track toggles 36->37->36 every 8 cycles during SETTLE (SETTLE=16) -> no sd_rd issued until track is stable for 16 cycles.
4. Pulse change during RD_WAIT for track 40 -> handshake completes, cur_track=FF, then a new read of the current track (lba=track*52) is issued.
5. track=170 (>=MAX_TRACK) with cur_track=36 -> no request, busy=0, cur_track stays 36.
6. With C157X_TRACK_TIMEOUT_EN, sd_rd asserted and sd_ack held 0 -> after 2^20-1 cycles sd_rd=0, err=1, cur_track=FF; a change rising edge clears err.
